// File: rtl/bram_adapter_pkg.sv
// Shared sizing helpers for the BRAM request/response adapter.
// BRAM_ADAPTER_PARITY_EN widens the BRAM word by one even-parity bit.
package bram_adapter_pkg;

   localparam int RL_MIN = 1;
   localparam int RL_MAX = 2;

   function automatic int clog2_f(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

   function automatic int ptr_w_f(input int depth);
      return (depth > 1) ? clog2_f(depth) : 1;
   endfunction

   // Counts 0..depth inclusive, so one more state than a pointer.
   function automatic int cnt_w_f(input int depth);
      return clog2_f(depth + 1);
   endfunction

   function automatic int bram_w_f(input int data_w);
`ifdef BRAM_ADAPTER_PARITY_EN
      return data_w + 1;
`else
      return data_w;
`endif
   endfunction

   function automatic bit rl_legal_f(input int rl);
      return (rl >= RL_MIN) && (rl <= RL_MAX);
   endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Response FIFO with a registered head: o_data/o_valid come straight from flops
// and the next head is selected ahead of time so back-to-back pops never bubble.
module bram_resp_fifo
   import bram_adapter_pkg::*;
#(
   parameter int W = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = ptr_w_f(DEPTH),
   localparam int CNT_W = cnt_w_f(DEPTH)
)(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [W-1:0]     i_push_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [W-1:0]     o_data,
   output logic [CNT_W-1:0] o_count
);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic [W-1:0]     r_data;

   logic             w_pop;
   logic [PTR_W-1:0] w_head_idx;
   logic [CNT_W-1:0] w_count_nxt;
   logic [W-1:0]     w_head_data;

   function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   assign w_pop = i_pop & r_valid;

   // The entry being pushed becomes the head only when it lands at the head slot.
   always_comb begin
      w_head_idx  = w_pop ? ptr_inc_f(r_rd_ptr) : r_rd_ptr;
      w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(w_pop);
      if (i_push && (r_wr_ptr == w_head_idx)) begin
         w_head_data = i_push_data;
      end else begin
         w_head_data = r_mem[w_head_idx];
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         r_valid  <= 1'b0;
         r_data   <= {W{1'b0}};
      end else begin
         if (i_push) begin
            r_wr_ptr <= ptr_inc_f(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc_f(r_rd_ptr);
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != {CNT_W{1'b0}});
         // Empty keeps the last delivered word visible.
         if (w_count_nxt != {CNT_W{1'b0}}) begin
            r_data <= w_head_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_count = r_count;

endmodule

// File: rtl/bram_req_resp_adapter.sv
// Valid/ready front-end for one no-change BRAM port; reads are credit-limited so
// returning data always has a FIFO slot. Optional BRAM_ADAPTER_PARITY_EN adds even parity.
module bram_req_resp_adapter
   import bram_adapter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH = 1024,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int ADDR_W = clog2_f(DEPTH),
   localparam int BRAM_W = bram_w_f(DATA_W),
   localparam int CNT_W = cnt_w_f(FIFO_DEPTH)
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_data,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_data,
`ifdef BRAM_ADAPTER_PARITY_EN
   output logic              o_resp_parity_err,
`endif
   output logic              o_bram_en,
   output logic              o_bram_we,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic [BRAM_W-1:0] o_bram_din,
   output logic              o_bram_regce,
   input  logic [BRAM_W-1:0] i_bram_dout,
   output logic              o_busy
);

   // Out-of-range latencies fall back to the output-registered BRAM setting.
   localparam int RL = rl_legal_f(READ_LATENCY) ? READ_LATENCY : RL_MAX;

   logic [CNT_W-1:0]  r_credit;
   logic [RL-1:0]     r_vpipe;

   logic              w_accept;
   logic              w_rd_accept;
   logic              w_pop;
   logic [BRAM_W-1:0] w_push_data;
   logic [BRAM_W-1:0] w_fifo_data;
   logic              w_fifo_valid;
   logic [CNT_W-1:0]  w_fifo_count;

   assign o_req_ready  = (r_credit != {CNT_W{1'b0}});
   assign w_accept     = i_req_valid & o_req_ready;
   assign w_rd_accept  = w_accept & ~i_req_write;
   assign w_pop        = w_fifo_valid & i_resp_ready;

   assign o_bram_en    = w_accept;
   assign o_bram_we    = w_accept & i_req_write;
   assign o_bram_addr  = i_req_addr;
   assign o_bram_regce = 1'b1;

`ifdef BRAM_ADAPTER_PARITY_EN
   assign o_bram_din  = {^i_req_data, i_req_data};
   // Top bit of a FIFO entry carries the parity verdict for its data word.
   assign w_push_data = {(^i_bram_dout[DATA_W-1:0]) != i_bram_dout[DATA_W],
                         i_bram_dout[DATA_W-1:0]};
   assign o_resp_parity_err = w_fifo_data[DATA_W];
`else
   assign o_bram_din  = i_req_data;
   assign w_push_data = i_bram_dout;
`endif

   assign o_resp_valid = w_fifo_valid;
   assign o_resp_data  = w_fifo_data[DATA_W-1:0];
   assign o_busy       = (|r_vpipe) | (w_fifo_count != {CNT_W{1'b0}});

   // One credit per free FIFO slot not already claimed by an in-flight read.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_credit <= CNT_W'(FIFO_DEPTH);
      end else begin
         case ({w_rd_accept, w_pop})
            2'b10:   r_credit <= r_credit - CNT_W'(1);
            2'b01:   r_credit <= r_credit + CNT_W'(1);
            default: r_credit <= r_credit;
         endcase
      end
   end

   // Shadows the BRAM read latency; the last stage marks valid bram_dout.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_vpipe <= {RL{1'b0}};
      end else begin
         r_vpipe[0] <= w_rd_accept;
         for (int i = 1; i < RL; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
      end
   end

   bram_resp_fifo #(
      .W     (BRAM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_resp_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (r_vpipe[RL-1]),
      .i_push_data (w_push_data),
      .i_pop       (i_resp_ready),
      .o_valid     (w_fifo_valid),
      .o_data      (w_fifo_data),
      .o_count     (w_fifo_count)
   );

endmodule

// File: tb/tb_bram_req_resp_adapter.sv
// Bench for bram_req_resp_adapter: behavioural no-change BRAM, reference memory
// and an in-order response scoreboard. Honours BRAM_ADAPTER_PARITY_EN.
module tb_bram_req_resp_adapter;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 1024;
   localparam int RL     = 2;
   localparam int FD     = 4;
   localparam int ADDR_W = 10;
`ifdef BRAM_ADAPTER_PARITY_EN
   localparam int BRAM_W = DATA_W + 1;
`else
   localparam int BRAM_W = DATA_W;
`endif

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
`ifdef BRAM_ADAPTER_PARITY_EN
   logic              resp_parity_err;
`endif
   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [BRAM_W-1:0] bram_din;
   logic              bram_regce;
   logic [BRAM_W-1:0] bram_dout;
   logic              busy;

   bram_req_resp_adapter #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .i_clock(clk), .i_reset(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_data(req_data),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
`ifdef BRAM_ADAPTER_PARITY_EN
      .o_resp_parity_err(resp_parity_err),
`endif
      .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
      .o_bram_din(bram_din), .o_bram_regce(bram_regce), .i_bram_dout(bram_dout),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- no-change BRAM model ----------------
   logic [BRAM_W-1:0] bmem [DEPTH];
   logic [BRAM_W-1:0] st1, st2;
   logic [BRAM_W-1:0] inj_mask;

   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) bmem[bram_addr] <= bram_din;
         else         st1 <= bmem[bram_addr] ^ inj_mask;
      end
      if (bram_regce) st2 <= st1;
   end
   assign bram_dout = (RL == 2) ? st2 : st1;

   function automatic logic [BRAM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef BRAM_ADAPTER_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] data;
      logic        perr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] cur_exp;
   logic        cur_perr;
   int          n_vec;
   int          n_err;
   logic        m_rdy;
   exp_t        m_ent;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // Outputs are judged at the negedge against the state the next posedge will commit.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         m_rdy = (sb.size() < FD);
         chk("req_ready", 32'(req_ready), 32'(m_rdy));
         chk("busy", 32'(busy), 32'(sb.size() != 0));
         chk("bram_en", 32'(bram_en), 32'(req_valid & m_rdy));
         chk("bram_we", 32'(bram_we), 32'(req_valid & m_rdy & req_write));
         if (req_valid) begin
            chk("bram_addr", 32'(bram_addr), 32'(req_addr));
            chk("bram_din", bram_din[31:0], req_data);
`ifdef BRAM_ADAPTER_PARITY_EN
            chk("bram_din_par", 32'(bram_din[BRAM_W-1]), 32'(^req_data));
`endif
         end
         if (sb.size() == 0) begin
            chk("resp_valid_idle", 32'(resp_valid), 32'd0);
         end else if (resp_valid) begin
            chk("resp_data", resp_data, sb[0].data);
`ifdef BRAM_ADAPTER_PARITY_EN
            chk("resp_parity_err", 32'(resp_parity_err), 32'(sb[0].perr));
`endif
            if (resp_ready) void'(sb.pop_front());
         end
         if (req_valid && m_rdy) begin
            if (req_write) begin
               ref_mem[req_addr] = req_data;
            end else begin
               m_ent.data = cur_exp;
               m_ent.perr = cur_perr;
               sb.push_back(m_ent);
            end
         end
      end
   end

   // ---------------- driver tasks (start and end at posedge+1) ----------------
   task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [31:0] e, input logic unstick, output int stalls);
      stalls    = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_data  = d;
      cur_exp   = e;
      @(negedge clk);
      while (!req_ready && stalls < 300) begin
         stalls++;
         if (unstick) resp_ready = 1'b1;
         @(negedge clk);
      end
      if (!req_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL req_timeout: actual=stalled required=accepted addr=%h", a);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_pending", 32'(sb.size()), 32'd0);
      if (sb.size() != 0) sb.delete();
   endtask

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [31:0]       exp;
   } vec_t;

   vec_t vt[10];
   int   st;
   int   bp_st;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
      resp_ready = 1'b1; inj_mask = '0; cur_exp = '0; cur_perr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = 32'h5A5A_0000 ^ i;
         bmem[i]    = enc(ref_mem[i]);
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_regce", 32'(bram_regce), 32'd1);
`ifdef BRAM_ADAPTER_PARITY_EN
      chk("rst_parity_err", 32'(resp_parity_err), 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven write/read vectors, including back-to-back same-address and edge addresses
      vt[0] = '{1'b1, 10'h020, 32'h1111_1111, 32'h0};
      vt[1] = '{1'b1, 10'h021, 32'h2222_2222, 32'h0};
      vt[2] = '{1'b0, 10'h020, 32'h0,         32'h1111_1111};
      vt[3] = '{1'b0, 10'h021, 32'h0,         32'h2222_2222};
      vt[4] = '{1'b1, 10'h020, 32'hA5A5_A5A5, 32'h0};
      vt[5] = '{1'b0, 10'h020, 32'h0,         32'hA5A5_A5A5};
      vt[6] = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 32'h0};
      vt[7] = '{1'b0, 10'h3FF, 32'h0,         32'hFFFF_FFFF};
      vt[8] = '{1'b1, 10'h000, 32'h0000_0000, 32'h0};
      vt[9] = '{1'b0, 10'h000, 32'h0,         32'h0000_0000};
      for (int i = 0; i < 10; i++) begin
         send(vt[i].wr, vt[i].addr, vt[i].data, vt[i].exp, 1'b0, st);
      end
      drain();

      // Read latency: accept at T, data visible at T+3
      send(1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, st);
      send(1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, st);
      @(negedge clk); chk("lat_t1_valid", 32'(resp_valid), 32'd0);
      @(negedge clk); chk("lat_t2_valid", 32'(resp_valid), 32'd0);
      @(negedge clk); chk("lat_t3_valid", 32'(resp_valid), 32'd1);
      chk("lat_t3_data", resp_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      drain();

      // Eight back-to-back reads at full throughput
      resp_ready = 1'b1;
      for (int a = 0; a < 8; a++) begin
         send(1'b0, ADDR_W'(a), 32'h0, ref_mem[a], 1'b0, st);
         chk("b2b_stall", 32'(st), 32'd0);
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk("b2b_done", 32'(sb.size()), 32'd0);
      drain();

      // Back-pressure: four accepts fill the credits, then release
      resp_ready = 1'b0;
      for (int a = 0; a < 4; a++) begin
         send(1'b0, ADDR_W'(10'h100 + a), 32'h0, ref_mem[10'h100 + a], 1'b0, st);
         chk("bp_fill_stall", 32'(st), 32'd0);
      end
      repeat (4) @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_full_valid", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
      fork
         begin
            send(1'b0, 10'h104, 32'h0, ref_mem[10'h104], 1'b0, bp_st);
            chk("bp_stalled", 32'(bp_st != 0), 32'd1);
            send(1'b0, 10'h105, 32'h0, ref_mem[10'h105], 1'b0, st);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            resp_ready = 1'b1;
         end
      join
      drain();

      // Reset with two reads in flight and one buffered
      resp_ready = 1'b0;
      send(1'b0, 10'h200, 32'h0, ref_mem[10'h200], 1'b0, st);
      send(1'b0, 10'h201, 32'h0, ref_mem[10'h201], 1'b0, st);
      send(1'b0, 10'h202, 32'h0, ref_mem[10'h202], 1'b0, st);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_data", resp_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (8) @(negedge clk);
      @(posedge clk); #1;
      send(1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, st);
      drain();

`ifdef BRAM_ADAPTER_PARITY_EN
      // Corrupted data bit must raise the parity flag; a clean read must not
      send(1'b1, 10'h030, 32'h0000_0001, 32'h0, 1'b0, st);
      inj_mask = BRAM_W'(1);
      cur_perr = 1'b1;
      send(1'b0, 10'h030, 32'h0, 32'h0000_0000, 1'b0, st);
      inj_mask = '0;
      cur_perr = 1'b0;
      send(1'b0, 10'h030, 32'h0, 32'h0000_0001, 1'b0, st);
      drain();
`endif

      // Random interleaved traffic with random consumer stalls
      for (int k = 0; k < 300; k++) begin
         logic              w;
         logic [ADDR_W-1:0] a;
         logic [31:0]       d;
         resp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end else begin
            w = 1'($urandom_range(0, 1));
            a = 10'h300 + ADDR_W'($urandom_range(0, 15));
            d = $urandom;
            send(w, a, d, w ? 32'h0 : ref_mem[a], 1'b1, st);
         end
      end
      resp_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
